// File: rtl/button_gesture.sv
// Turns a debounced button level into one-cycle gesture pulses plus held/busy levels.
// Latency: every output is registered and changes on the edge that samples the btn edge or terminal count.
// No backpressure: pulses are fire-and-forget. release/repeat are keywords, hence the _evt port names.
module button_gesture #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic release_evt,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic repeat_evt,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             dclick_q, dclick_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic             busy_q, busy_d;

  logic rise, fall, long_tc, dclick_tc, repeat_tc, repeat_hit;

  // Edge detection against the previous sample, plus terminal-count decodes
  always_comb begin
    btn_d      = btn;
    rise       = btn & ~btn_q;
    fall       = ~btn & btn_q;
    long_tc    = (cnt_q == LONG_TC);
    dclick_tc  = (cnt_q == DCLICK_TC);
    repeat_tc  = (cnt_q == REPEAT_TC);
    // A release in the same cycle as the repeat terminal suppresses the repeat
    repeat_hit = (state_q == LONG) && !fall && repeat_tc;
  end

  // State, counter and input-history registers; btn_q resets high so a button
  // held through reset must be released before it can produce a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
    end
  end

  // Next state: btn edges are tested before terminal counts so edges always win
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = PRESS1;
      PRESS1:  if (fall) state_d = WAIT2;
               else if (long_tc && btn) state_d = LONG;
      WAIT2:   if (rise) state_d = PRESS2;
               else if (dclick_tc) state_d = IDLE;
      PRESS2:  if (fall) state_d = IDLE;
               else if (long_tc) state_d = LONG;
      LONG:    if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counter restarts on every state entry and on each repeat period
    if ((state_d != state_q) || (state_q == IDLE) || repeat_hit) cnt_d = '0;
    else cnt_d = cnt_q + CNT_W'(1);
  end

  // Output decode: pulses for the transition being taken on this edge
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      IDLE:    press_d = rise;
      PRESS1:  begin
                 release_d = fall;
                 long_d    = !fall && long_tc && btn;
               end
      WAIT2:   begin
                 press_d = rise;
                 click_d = !rise && dclick_tc;
               end
      PRESS2:  begin
                 release_d = fall;
                 dclick_d  = fall;
                 // The first tap still counts as a click when the second turns long
                 click_d   = !fall && long_tc;
                 long_d    = !fall && long_tc;
               end
      LONG:    begin
                 release_d = fall;
                 repeat_d  = repeat_hit;
               end
      default: ;
    endcase
    held_d = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG);
    busy_d = (state_d != IDLE);
  end

  // Output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      busy_q    <= busy_d;
    end
  end

  assign press       = press_q;
  assign release_evt = release_q;
  assign click       = click_q;
  assign dclick      = dclick_q;
  assign long_press  = long_q;
  assign repeat_evt  = repeat_q;
  assign held        = held_q;
  assign busy        = busy_q;

endmodule
